// File: rtl/twpm_ram_arbiter_if.sv
// Requester-side buses of the TPM buffer arbiter: the Wishbone slave window and the
// regs_module byte port, both synchronous to the arbiter clock.
interface twpm_ram_arbiter_if #(
  parameter int RAM_ADDR_WIDTH = 11
);
  logic                      wb_cyc_i;
  logic                      wb_stb_i;
  logic                      wb_we_i;
  logic [RAM_ADDR_WIDTH-3:0] wb_adr_i;
  logic [3:0]                wb_sel_i;
  logic [31:0]               wb_dat_i;
  logic [31:0]               wb_dat_o;
  logic                      wb_ack_o;
  logic                      wb_err_o;
  logic                      dp_req_i;
  logic                      dp_we_i;
  logic [RAM_ADDR_WIDTH-1:0] dp_addr_i;
  logic [7:0]                dp_wdata_i;
  logic [7:0]                dp_rdata_o;
  logic                      dp_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output dp_req_i, dp_we_i, dp_addr_i, dp_wdata_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, dp_rdata_o, dp_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  dp_req_i, dp_we_i, dp_addr_i, dp_wdata_i,
    output wb_dat_o, wb_ack_o, wb_err_o, dp_rdata_o, dp_ack_o
  );
endinterface

// File: rtl/twpm_ram_arbiter.sv
// Single-clock owner arbiter for the 512x32 TPM buffer RAM: exec_i picks Wishbone or the
// data provider, each access is sequenced IDLE-ISSUE-READ-RESP, non-owner requests are rejected.
module twpm_ram_arbiter #(
  parameter int         RAM_ADDR_WIDTH = 11,
  parameter logic [7:0] DP_REJECT_DATA = 8'hFF
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      exec_i,
  twpm_ram_arbiter_if.slave         bus,
  output logic [RAM_ADDR_WIDTH-3:0] ram_a_o,
  output logic [31:0]               ram_wd_o,
  output logic [3:0]                ram_wen_o,
  input  logic [31:0]               ram_rd_i,
  output logic                      owner_o,
  output logic [7:0]                viol_cnt_o,
  input  logic                      viol_clr_i
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_REJECT = 3'd4;

  logic [2:0]                state_r;
  logic                      owner_r;
  logic [1:0]                lane_r;
  logic [RAM_ADDR_WIDTH-3:0] ram_a_r;
  logic [31:0]               ram_wd_r;
  logic [3:0]                ram_wen_r;
  logic [31:0]               wb_dat_r;
  logic                      wb_ack_r;
  logic                      wb_err_r;
  logic [7:0]                dp_rdata_r;
  logic                      dp_ack_r;
  logic [7:0]                viol_cnt_r;

  logic                      wb_req_s;
  logic                      own_req_s;
  logic                      rej_req_s;
  logic                      reject_s;
  logic [1:0]                dp_lane_s;
  logic [31:0]               dp_wd_s;
  logic [3:0]                dp_wen_s;
  logic [7:0]                rd_byte_s;

  // Request decode against the live exec_i and byte-lane steering for the DP port
  always_comb begin
    wb_req_s  = bus.wb_cyc_i & bus.wb_stb_i;
    own_req_s = exec_i ? wb_req_s : bus.dp_req_i;
    rej_req_s = exec_i ? bus.dp_req_i : wb_req_s;
    reject_s  = (state_r == ST_IDLE) && !own_req_s && rej_req_s;
    dp_lane_s = bus.dp_addr_i[1:0];
    dp_wd_s   = {24'd0, bus.dp_wdata_i} << {dp_lane_s, 3'b000};
    dp_wen_s  = bus.dp_we_i ? (4'b0001 << dp_lane_s) : 4'b0000;
    case (lane_r)
      2'd0:    rd_byte_s = ram_rd_i[7:0];
      2'd1:    rd_byte_s = ram_rd_i[15:8];
      2'd2:    rd_byte_s = ram_rd_i[23:16];
      default: rd_byte_s = ram_rd_i[31:24];
    endcase
  end

  // Access sequencer; owner_r only moves in IDLE so an in-flight access keeps its owner
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= ST_IDLE;
      owner_r    <= 1'b0;
      lane_r     <= 2'd0;
      ram_a_r    <= '0;
      ram_wd_r   <= 32'd0;
      ram_wen_r  <= 4'b0000;
      wb_dat_r   <= 32'd0;
      wb_ack_r   <= 1'b0;
      wb_err_r   <= 1'b0;
      dp_rdata_r <= 8'd0;
      dp_ack_r   <= 1'b0;
    end else begin
      wb_ack_r <= 1'b0;
      wb_err_r <= 1'b0;
      dp_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          owner_r <= exec_i;
          if (own_req_s) begin
            state_r <= ST_ISSUE;
            if (exec_i) begin
              ram_a_r   <= bus.wb_adr_i;
              ram_wd_r  <= bus.wb_dat_i;
              ram_wen_r <= bus.wb_we_i ? bus.wb_sel_i : 4'b0000;
            end else begin
              ram_a_r   <= bus.dp_addr_i[RAM_ADDR_WIDTH-1:2];
              ram_wd_r  <= dp_wd_s;
              ram_wen_r <= dp_wen_s;
              lane_r    <= dp_lane_s;
            end
          end else if (rej_req_s) begin
            // The rejection answer goes out in the very next cycle
            state_r <= ST_REJECT;
            if (exec_i) begin
              dp_ack_r   <= 1'b1;
              dp_rdata_r <= DP_REJECT_DATA;
            end else begin
              wb_err_r <= 1'b1;
              wb_dat_r <= 32'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          ram_wen_r <= 4'b0000;
          state_r   <= ST_READ;
        end
        ST_READ: begin
          state_r <= ST_RESP;
          if (owner_r) begin
            wb_ack_r <= 1'b1;
            wb_dat_r <= ram_rd_i;
          end else begin
            dp_ack_r   <= 1'b1;
            dp_rdata_r <= rd_byte_s;
          end
        end
        ST_RESP:   state_r <= ST_IDLE;
        ST_REJECT: state_r <= ST_IDLE;
        default: begin
          state_r   <= ST_IDLE;
          ram_wen_r <= 4'b0000;
        end
      endcase
    end
  end

  // Saturating rejection counter; a clear beats a same-cycle increment
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      viol_cnt_r <= 8'd0;
    end else if (viol_clr_i) begin
      viol_cnt_r <= 8'd0;
    end else if (reject_s && (viol_cnt_r != 8'hFF)) begin
      viol_cnt_r <= viol_cnt_r + 8'd1;
    end else begin
      viol_cnt_r <= viol_cnt_r;
    end
  end

  assign ram_a_o        = ram_a_r;
  assign ram_wd_o       = ram_wd_r;
  assign ram_wen_o      = ram_wen_r;
  assign owner_o        = owner_r;
  assign viol_cnt_o     = viol_cnt_r;
  assign bus.wb_dat_o   = wb_dat_r;
  assign bus.wb_ack_o   = wb_ack_r;
  assign bus.wb_err_o   = wb_err_r;
  assign bus.dp_rdata_o = dp_rdata_r;
  assign bus.dp_ack_o   = dp_ack_r;

endmodule

// File: tb/tb_twpm_ram_arbiter.sv
// Directed plus randomized bench for twpm_ram_arbiter, with a byte-array model of the
// buffer contents and a saturating rejection-count model.
module tb_twpm_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        exec_i;
  logic        viol_clr_i;
  logic        ram_clear;
  logic [8:0]  ram_a_o;
  logic [31:0] ram_wd_o;
  logic [3:0]  ram_wen_o;
  logic [31:0] ram_rd_i;
  logic        owner_o;
  logic [7:0]  viol_cnt_o;

  logic [31:0] ram [0:511];
  logic [7:0]  ref_mem [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          exp_viol = 0;

  twpm_ram_arbiter_if #(.RAM_ADDR_WIDTH(11)) bus ();

  twpm_ram_arbiter #(.RAM_ADDR_WIDTH(11), .DP_REJECT_DATA(8'hFF)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .exec_i     (exec_i),
    .bus        (bus),
    .ram_a_o    (ram_a_o),
    .ram_wd_o   (ram_wd_o),
    .ram_wen_o  (ram_wen_o),
    .ram_rd_i   (ram_rd_i),
    .owner_o    (owner_o),
    .viol_cnt_o (viol_cnt_o),
    .viol_clr_i (viol_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous 512x32 RAM with byte write enables and registered read data
  always @(posedge clk_i) begin
    if (ram_clear) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'd0;
    end else begin
      ram_rd_i <= ram[ram_a_o];
      for (int b = 0; b < 4; b++)
        if (ram_wen_o[b]) ram[ram_a_o][8*b +: 8] <= ram_wd_o[8*b +: 8];
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic bump_viol;
    if (exp_viol < 255) exp_viol++;
  endtask

  // One Wishbone transfer starting in an idle cycle; owner or reject decided by exec_i
  task automatic wb_op(input logic we, input int w, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] exp_rd;
    exp_rd = model_word(w);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = 9'(w); bus.wb_sel_i = sel; bus.wb_dat_i = dat;
    if (exec_i) begin
      tick;
      check("wb_wen_n1", 32'(ram_wen_o), we ? 32'(sel) : 32'd0);
      check("wb_addr_n1", 32'(ram_a_o), 32'(w));
      if (we) check("wb_wd_n1", ram_wd_o, dat);
      check("wb_ack_n1", 32'(bus.wb_ack_o), 32'd0);
      tick;
      check("wb_wen_n2", 32'(ram_wen_o), 32'd0);
      check("wb_ack_n2", 32'(bus.wb_ack_o), 32'd0);
      tick;
      check("wb_ack_n3", 32'(bus.wb_ack_o), 32'd1);
      check("wb_err_n3", 32'(bus.wb_err_o), 32'd0);
      if (!we) check("wb_rdata", bus.wb_dat_o, exp_rd);
      if (we) for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[4*w+b] = dat[8*b +: 8];
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      tick;
      check("wb_ack_n4", 32'(bus.wb_ack_o), 32'd0);
    end else begin
      tick;
      bump_viol();
      check("wb_err_n1", 32'(bus.wb_err_o), 32'd1);
      check("wb_err_dat", bus.wb_dat_o, 32'd0);
      check("wb_rej_wen", 32'(ram_wen_o), 32'd0);
      check("wb_rej_viol", 32'(viol_cnt_o), 32'(exp_viol));
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      tick;
      check("wb_err_n2", 32'(bus.wb_err_o), 32'd0);
    end
  endtask

  // One data-provider byte transfer starting in an idle cycle
  task automatic dp_op(input logic we, input int a, input logic [7:0] d);
    logic [7:0] exp_rd;
    int k;
    k = a % 4;
    exp_rd = ref_mem[a];
    bus.dp_req_i = 1'b1; bus.dp_we_i = we; bus.dp_addr_i = 11'(a); bus.dp_wdata_i = d;
    if (!exec_i) begin
      tick;
      check("dp_wen_n1", 32'(ram_wen_o), we ? (32'd1 << k) : 32'd0);
      check("dp_addr_n1", 32'(ram_a_o), 32'(a / 4));
      if (we) check("dp_wd_n1", ram_wd_o, 32'(d) << (8 * k));
      tick;
      check("dp_wen_n2", 32'(ram_wen_o), 32'd0);
      check("dp_ack_n2", 32'(bus.dp_ack_o), 32'd0);
      tick;
      check("dp_ack_n3", 32'(bus.dp_ack_o), 32'd1);
      if (!we) check("dp_rdata", 32'(bus.dp_rdata_o), 32'(exp_rd));
      if (we) ref_mem[a] = d;
      bus.dp_req_i = 1'b0;
      tick;
      check("dp_ack_n4", 32'(bus.dp_ack_o), 32'd0);
    end else begin
      tick;
      bump_viol();
      check("dp_rej_ack", 32'(bus.dp_ack_o), 32'd1);
      check("dp_rej_data", 32'(bus.dp_rdata_o), 32'hFF);
      check("dp_rej_wen", 32'(ram_wen_o), 32'd0);
      check("dp_rej_viol", 32'(viol_cnt_o), 32'(exp_viol));
      bus.dp_req_i = 1'b0;
      tick;
      check("dp_rej_ack_n2", 32'(bus.dp_ack_o), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; exec_i = 1'b0; viol_clr_i = 1'b0; ram_clear = 1'b1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd0;
    bus.wb_sel_i = 4'd0; bus.wb_dat_i = 32'd0;
    bus.dp_req_i = 1'b0; bus.dp_we_i = 1'b0; bus.dp_addr_i = 11'd0; bus.dp_wdata_i = 8'd0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'd0;
    tick; tick;
    check("rst_ram_a", 32'(ram_a_o), 32'd0);
    check("rst_ram_wd", ram_wd_o, 32'd0);
    check("rst_ram_wen", 32'(ram_wen_o), 32'd0);
    check("rst_outs", {25'd0, bus.wb_ack_o, bus.wb_err_o, bus.dp_ack_o, owner_o, 3'd0}, 32'd0);
    check("rst_wb_dat", bus.wb_dat_o, 32'd0);
    check("rst_dp_rdata", 32'(bus.dp_rdata_o), 32'd0);
    check("rst_viol", 32'(viol_cnt_o), 32'd0);
    ram_clear = 1'b0;
    @(negedge clk_i); rstn_i = 1'b1;
    tick;

    // Basic Wishbone write/read
    exec_i = 1'b1;
    wb_op(1'b1, 5, 4'hF, 32'hDEADBEEF);
    wb_op(1'b0, 5, 4'hF, 32'd0);
    check("owner_wb", 32'(owner_o), 32'd1);

    // DP byte writes assembled into a word, then DP byte read
    exec_i = 1'b0;
    dp_op(1'b1, 32'h20, 8'h11);
    dp_op(1'b1, 32'h21, 8'h22);
    dp_op(1'b1, 32'h22, 8'h33);
    dp_op(1'b1, 32'h23, 8'h44);
    exec_i = 1'b1;
    wb_op(1'b0, 8, 4'hF, 32'd0);
    check("word8_model", model_word(8), 32'h44332211);
    exec_i = 1'b0;
    dp_op(1'b0, 32'h22, 8'h00);

    // Non-owner rejections, RAM untouched
    wb_op(1'b0, 0, 4'hF, 32'd0);
    exec_i = 1'b1;
    dp_op(1'b1, 32'h21, 8'h99);
    wb_op(1'b0, 8, 4'hF, 32'd0);

    // Simultaneous WB (owner) and DP (non-owner) requests
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd5;
    bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b1; bus.dp_addr_i = 11'h40; bus.dp_wdata_i = 8'hAB;
    tick; tick; tick;
    check("sim_wb_ack", 32'(bus.wb_ack_o), 32'd1);
    check("sim_wb_dat", bus.wb_dat_o, model_word(5));
    check("sim_dp_ack_n3", 32'(bus.dp_ack_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick;
    check("sim_dp_ack_n4", 32'(bus.dp_ack_o), 32'd0);
    tick;
    bump_viol();
    check("sim_dp_ack_n5", 32'(bus.dp_ack_o), 32'd1);
    check("sim_dp_rdata", 32'(bus.dp_rdata_o), 32'hFF);
    check("sim_viol", 32'(viol_cnt_o), 32'(exp_viol));
    bus.dp_req_i = 1'b0;
    tick;
    wb_op(1'b0, 16, 4'hF, 32'd0);

    // exec_i flips during an in-flight WB write
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 9'd3;
    bus.wb_sel_i = 4'h6; bus.wb_dat_i = 32'hCAFE1234;
    tick;
    check("flip_wen", 32'(ram_wen_o), 32'h6);
    exec_i = 1'b0;
    tick; tick;
    check("flip_ack", 32'(bus.wb_ack_o), 32'd1);
    ref_mem[13] = 8'h12; ref_mem[14] = 8'hFE;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick;
    check("flip_owner_n4", 32'(owner_o), 32'd1);
    tick;
    check("flip_owner_n5", 32'(owner_o), 32'd0);
    exec_i = 1'b1;
    wb_op(1'b0, 3, 4'hF, 32'd0);

    // Saturation of the rejection counter, then clear against a rejection
    exec_i = 1'b0;
    for (int i = 0; i < 300; i++) wb_op(1'b0, i % 512, 4'hF, 32'd0);
    check("viol_sat", 32'(viol_cnt_o), 32'hFF);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd1;
    viol_clr_i = 1'b1;
    tick;
    viol_clr_i = 1'b0;
    exp_viol = 0;
    check("clr_err", 32'(bus.wb_err_o), 32'd1);
    check("clr_viol", 32'(viol_cnt_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick;

    // Reset in the middle of a write issue
    exec_i = 1'b1;
    dp_op(1'b1, 32'h10, 8'h77);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 9'd9;
    bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h5A5A5A5A;
    tick;
    check("rstmid_wen_pre", 32'(ram_wen_o), 32'hF);
    #1 rstn_i = 1'b0;
    #1;
    check("rstmid_wen", 32'(ram_wen_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    exp_viol = 0;
    tick;
    check("rstmid_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rstmid_viol", 32'(viol_cnt_o), 32'd0);
    check("rstmid_owner", 32'(owner_o), 32'd0);
    @(negedge clk_i); rstn_i = 1'b1;
    tick;
    check("rstmid_noack", 32'(bus.wb_ack_o), 32'd0);
    wb_op(1'b0, 9, 4'hF, 32'd0);
    wb_op(1'b1, 9, 4'hF, 32'h5A5A5A5A);
    wb_op(1'b0, 9, 4'hF, 32'd0);

    // Randomized mix against the reference model
    for (int i = 0; i < 200; i++) begin
      exec_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        wb_op(1'($urandom_range(0, 1)), $urandom_range(0, 15), 4'($urandom), $urandom);
      else
        dp_op(1'($urandom_range(0, 1)), $urandom_range(0, 63), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twpm_ram_arbiter.md
# twpm_ram_arbiter

Single-clock arbiter and sequencer for the 512x32 TPM command/response buffer RAM. It replaces the exec-driven clock/address mux: the NeoRV32 Wishbone port and the regs_module byte port both run in `clk_i`, and the arbiter alone drives the RAM. Ownership follows `exec_i`, with exec=1 giving the CPU ownership and exec=0 giving the data provider ownership. Accesses are sequenced so that ownership can never change mid-access and write enables are glitch-free. Non-owner accesses are rejected and counted.

## Interface
- RAM_ADDR_WIDTH, 11, byte address width of the buffer (RAM word address = RAM_ADDR_WIDTH-2 bits)
- DP_REJECT_DATA, 8'hFF, read data returned to rejected data-provider reads
- clk_i  in  1  system clock (CPU/Wishbone clock); RAM is clocked by clk_i
- rstn_i  in  1  asynchronous active-low reset
- exec_i  in  1  ownership select: 1 = Wishbone owns RAM, 0 = data provider owns RAM
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle/strobe/write (already decoded to RAM window)
- wb_adr_i  in  RAM_ADDR_WIDTH-2  word address
- wb_sel_i  in  4  byte enables
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o=1
- wb_ack_o  out  1  one-cycle transfer acknowledge
- wb_err_o  out  1  one-cycle error (non-owner access)
- dp_req_i  in  1  data-provider request, level, held until dp_ack_o
- dp_we_i  in  1  1 = write byte
- dp_addr_i  in  RAM_ADDR_WIDTH  byte address
- dp_wdata_i  in  8  write byte
- dp_rdata_o  out  8  read byte, valid while dp_ack_o=1
- dp_ack_o  out  1  one-cycle acknowledge
- ram_a_o  out  RAM_ADDR_WIDTH-2  RAM word address (registered)
- ram_wd_o  out  32  RAM write data (registered)
- ram_wen_o  out  4  RAM byte write enables (registered)
- ram_rd_i  in  32  RAM read data, valid one cycle after ram_a_o is sampled
- owner_o  out  1  latched owner (1 = Wishbone)
- viol_cnt_o  out  8  saturating count of rejected accesses
- viol_clr_i  in  1  synchronous clear of viol_cnt_o

## Operation
- FSM states: IDLE, ISSUE, READ, RESP, REJECT.
- IDLE: owner_q <= exec_i every cycle. The owner is evaluated on exec_i in the same cycle.
  - Owner request (wb_cyc&wb_stb if exec_i=1, dp_req if exec_i=0): latch the address, data and enables into ram_*_o, go to ISSUE.
  - Otherwise, a non-owner request: go to REJECT.
  - Otherwise: stay in IDLE.
- The owner's request always wins over a simultaneous non-owner request. The non-owner request is rejected later, once the owner goes idle.
- ISSUE: the RAM samples ram_a_o/ram_wen_o at the end of this cycle. Next state is READ, and ram_wen_o <= 0.
- READ: capture the read data (ram_rd_i) into the response register. Next state is RESP.
- RESP: pulse wb_ack_o or dp_ack_o for the latched owner. Next state is IDLE.
- REJECT: no RAM access, and ram_wen_o stays 0.
  - A Wishbone request is answered with a wb_err_o pulse and wb_dat_o=0.
  - A data-provider request is answered with a dp_ack_o pulse and dp_rdata_o=DP_REJECT_DATA; its write is dropped.
  - viol_cnt_o increments, saturating at 8'hFF. Next state is IDLE.
- Wishbone lanes:
  - ram_wd_o = wb_dat_i.
  - ram_wen_o = wb_we_i ? wb_sel_i : 0. A write with sel=0 performs no write but is still acked.
  - wb_dat_o = the full captured word.
- DP lanes, with k = dp_addr_i[1:0]:
  - ram_a_o = dp_addr_i[RAM_ADDR_WIDTH-1:2].
  - ram_wd_o = dp_wdata_i shifted to bits [8k+7:8k], with the other bytes 0.
  - ram_wen_o = dp_we_i ? (4'b0001<<k) : 0.
  - dp_rdata_o = captured[8k+7:8k]. k is latched in IDLE.
- exec_i changing during ISSUE/READ/RESP/REJECT has no effect: the in-flight access completes under owner_q. The new owner applies in the next IDLE.
- viol_clr_i has priority over an increment in the same cycle, and the result is 0.
- There is no address wrap logic: the word address is truncated to RAM_ADDR_WIDTH-2 bits by width.

## Timing
- Reset (async, immediate):
  - State = IDLE.
  - All outputs are 0: ram_a_o, ram_wd_o, ram_wen_o=0, wb_ack_o, wb_err_o, wb_dat_o, dp_ack_o, dp_rdata_o, owner_o, viol_cnt_o.
  - Reset during ISSUE cancels the write-enable at once. A requester left waiting re-issues its request after reset.
- Owner access: request first high in IDLE at cycle N → ram_wen_o high exactly in cycle N+1 → ack high in cycle N+3 only. Latency is 3 cycles, and the next access is accepted no earlier than N+4.
- Rejected access: request in IDLE at cycle N → err/ack in cycle N+1.
- Requesters must drop stb/req in the cycle after the ack. A request still high at N+4 is treated as a new access.
- ram_wen_o is never high for more than one consecutive cycle.
- Throughput is 1 access per 4 cycles.

## Test plan
- exec_i=1; WB write 0xDEADBEEF, sel=4'hF, to word 5; WB read of word 5 → ram_wen_o=4'hF in N+1 only; read ack at N+3 with wb_dat_o=0xDEADBEEF.
- exec_i=0; DP writes 0x11,0x22,0x33,0x44 to bytes 0x20..0x23; exec_i=1; WB read of word 8 → 0x44332211. DP read of byte 0x22 (exec_i=0) → dp_rdata_o=0x33.
- exec_i=0; WB read of word 0 → wb_err_o in N+1, no ram_wen_o, viol_cnt_o=1. exec_i=1; DP write → dp_ack_o in N+1, RAM unchanged, viol_cnt_o=2.
- WB and DP requests in the same cycle with exec_i=1 → WB acked at N+3, DP rejected at N+5; exec_i toggled to 0 during WB ISSUE → WB access still acked, owner_o=0 from next IDLE.
- 300 rejected accesses → viol_cnt_o saturates at 0xFF; viol_clr_i together with a rejection → 0.
- rstn_i low during ISSUE of a write → ram_wen_o=0 immediately, no ack; after release the state is IDLE and the next request is served with 3-cycle latency.
